// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: accepts one line in IDLE and streams its pixels with
// valid/ready handshake, followed by a single-cycle done pulse.
module line_rasterizer #(
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int COLOR_W = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [X_W-1:0]     x0,
    input  logic [Y_W-1:0]     y0,
    input  logic [X_W-1:0]     x1,
    input  logic [Y_W-1:0]     y1,
    input  logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [X_W-1:0]     pix_x,
    output logic [Y_W-1:0]     pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               done
);
    localparam int W = ((X_W > Y_W) ? X_W : Y_W) + 2;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    state_t               state_reg;
    logic [X_W-1:0]       x0_reg, x1_reg, x_reg;
    logic [Y_W-1:0]       y0_reg, y1_reg, y_reg;
    logic [COLOR_W-1:0]   color_reg;
    logic signed [W-1:0]  dx_reg, dy_reg, err_reg;
    logic                 sx_neg_reg, sy_neg_reg;
    logic                 busy_reg, pix_valid_reg, done_reg;

    logic signed [W-1:0]  diff_x, diff_y, abs_x, abs_y, err_next;
    logic signed [W:0]    e2, dx_ext, dy_ext;
    logic                 step_x, step_y, at_end;
    logic [X_W-1:0]       x_next;
    logic [Y_W-1:0]       y_next;

    always_comb begin
        diff_x   = $signed({{(W-X_W){1'b0}}, x1_reg}) - $signed({{(W-X_W){1'b0}}, x0_reg});
        diff_y   = $signed({{(W-Y_W){1'b0}}, y1_reg}) - $signed({{(W-Y_W){1'b0}}, y0_reg});
        abs_x    = diff_x[W-1] ? -diff_x : diff_x;
        abs_y    = diff_y[W-1] ? -diff_y : diff_y;
        // e2 is one bit wider than err so doubling can never overflow
        e2       = {err_reg, 1'b0};
        dx_ext   = {dx_reg[W-1], dx_reg};
        dy_ext   = {dy_reg[W-1], dy_reg};
        step_x   = (e2 >= dy_ext);
        step_y   = (e2 <= dx_ext);
        err_next = err_reg + (step_x ? dy_reg : '0) + (step_y ? dx_reg : '0);
        x_next   = x_reg;
        y_next   = y_reg;
        if (step_x) x_next = sx_neg_reg ? x_reg - X_W'(1) : x_reg + X_W'(1);
        if (step_y) y_next = sy_neg_reg ? y_reg - Y_W'(1) : y_reg + Y_W'(1);
        at_end   = (x_reg == x1_reg) && (y_reg == y1_reg);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg     <= IDLE;
            x0_reg        <= '0;
            y0_reg        <= '0;
            x1_reg        <= '0;
            y1_reg        <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            color_reg     <= '0;
            dx_reg        <= '0;
            dy_reg        <= '0;
            err_reg       <= '0;
            sx_neg_reg    <= 1'b0;
            sy_neg_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            pix_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x0_reg    <= x0;
                        y0_reg    <= y0;
                        x1_reg    <= x1;
                        y1_reg    <= y1;
                        color_reg <= color;
                        busy_reg  <= 1'b1;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    dx_reg        <= abs_x;
                    dy_reg        <= -abs_y;
                    err_reg       <= abs_x - abs_y;
                    sx_neg_reg    <= !(x0_reg < x1_reg);
                    sy_neg_reg    <= !(y0_reg < y1_reg);
                    x_reg         <= x0_reg;
                    y_reg         <= y0_reg;
                    pix_valid_reg <= 1'b1;
                    state_reg     <= DRAW;
                end
                DRAW: begin
                    if (pix_ready) begin
                        if (at_end) begin
                            pix_valid_reg <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            err_reg <= err_next;
                            x_reg   <= x_next;
                            y_reg   <= y_next;
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = busy_reg;
    assign pix_valid = pix_valid_reg;
    assign pix_x     = x_reg;
    assign pix_y     = y_reg;
    assign pix_color = color_reg;
    assign done      = done_reg;
endmodule

// File: tb/tb_line_rasterizer.sv
// Directed testbench for line_rasterizer: hand-computed pixel sequences, backpressure,
// ignored start, degenerate line and mid-line reset.
module tb_line_rasterizer;
    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic [9:0] x0, y0, x1, y1;
    logic [7:0] color;
    logic       busy, pix_valid, pix_ready, done;
    logic [9:0] pix_x, pix_y;
    logic [7:0] pix_color;

    int checks   = 0;
    int failures = 0;
    int ex[8];
    int ey[8];

    line_rasterizer #(.X_W(10), .Y_W(10), .COLOR_W(8)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
        .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1, input int col);
        x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1); color = 8'(col);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start a line at full throughput and check every pixel against ex/ey.
    task automatic run_line(input string name, input int ax0, input int ay0, input int ax1,
                            input int ay1, input int col, input int npix);
        issue(ax0, ay0, ax1, ay1, col);
        check({name, "_setup_busy"}, 32'(busy), 1);
        check({name, "_setup_valid"}, 32'(pix_valid), 0);
        for (int i = 0; i < npix; i++) begin
            @(negedge clk);
            check($sformatf("%s_valid%0d", name, i), 32'(pix_valid), 1);
            check($sformatf("%s_x%0d", name, i), 32'(pix_x), 32'(ex[i]));
            check($sformatf("%s_y%0d", name, i), 32'(pix_y), 32'(ey[i]));
            check($sformatf("%s_col%0d", name, i), 32'(pix_color), 32'(col));
        end
        @(negedge clk);
        check({name, "_done"}, 32'(done), 1);
        check({name, "_done_valid"}, 32'(pix_valid), 0);
        check({name, "_done_busy"}, 32'(busy), 1);
        @(negedge clk);
        check({name, "_done_clear"}, 32'(done), 0);
        check({name, "_idle_busy"}, 32'(busy), 0);
        $display("line %s (%0d,%0d)->(%0d,%0d) pixels=%0d", name, ax0, ay0, ax1, ay1, npix);
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; pix_ready = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(pix_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_x", 32'(pix_x), 0);
        check("rst_y", 32'(pix_y), 0);
        check("rst_col", 32'(pix_color), 0);
        n_rst = 1'b1;
        @(negedge clk);

        ex = '{0, 1, 2, 3, 0, 0, 0, 0}; ey = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_line("horiz", 0, 0, 3, 0, 8'hA5, 4);

        ex = '{5, 4, 3, 2, 0, 0, 0, 0}; ey = '{5, 4, 3, 2, 0, 0, 0, 0};
        run_line("rdiag", 5, 5, 2, 2, 8'h3C, 4);

        ex = '{0, 0, 1, 1, 0, 0, 0, 0}; ey = '{0, 1, 2, 3, 0, 0, 0, 0};
        run_line("steep", 0, 0, 1, 3, 8'h11, 4);

        // Backpressure on the second pixel, with a start pulse during the stall
        issue(0, 0, 3, 0, 8'h5A);
        @(negedge clk);
        check("bp_px0_x", 32'(pix_x), 0);
        @(negedge clk);
        check("bp_px1_x", 32'(pix_x), 1);
        pix_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                x0 = 10'd50; y0 = 10'd60; x1 = 10'd70; y1 = 10'd80; color = 8'hFF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", i), 32'(pix_valid), 1);
            check($sformatf("bp_hold%0d_x", i), 32'(pix_x), 1);
            check($sformatf("bp_hold%0d_y", i), 32'(pix_y), 0);
            check($sformatf("bp_hold%0d_col", i), 32'(pix_color), 8'h5A);
        end
        start = 1'b0;
        pix_ready = 1'b1;
        @(negedge clk);
        check("bp_px2_x", 32'(pix_x), 2);
        check("bp_px2_col", 32'(pix_color), 8'h5A);
        @(negedge clk);
        check("bp_px3_x", 32'(pix_x), 3);
        check("bp_px3_y", 32'(pix_y), 0);
        @(negedge clk);
        check("bp_done", 32'(done), 1);
        @(negedge clk);
        check("bp_idle_busy", 32'(busy), 0);
        @(negedge clk);
        check("bp_no_restart", 32'(busy), 0);
        $display("line backpressure (0,0)->(3,0) stall=3");

        ex = '{7, 0, 0, 0, 0, 0, 0, 0}; ey = '{9, 0, 0, 0, 0, 0, 0, 0};
        run_line("degen", 7, 9, 7, 9, 8'h42, 1);

        // Mid-line reset after two accepted pixels
        issue(0, 0, 9, 0, 8'h77);
        @(negedge clk);
        check("rl_px0_x", 32'(pix_x), 0);
        @(negedge clk);
        check("rl_px1_x", 32'(pix_x), 1);
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        check("rl_busy", 32'(busy), 0);
        check("rl_valid", 32'(pix_valid), 0);
        check("rl_done", 32'(done), 0);
        check("rl_x", 32'(pix_x), 0);
        check("rl_col", 32'(pix_color), 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("rl_quiet%0d", i), 32'({done, pix_valid, busy}), 0);
        end
        $display("line reset-abort (0,0)->(9,0) after 2 pixels");

        ex = '{1, 2, 3, 0, 0, 0, 0, 0}; ey = '{1, 2, 2, 0, 0, 0, 0, 0};
        run_line("post_rst", 1, 1, 3, 2, 8'hC3, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
